voice_mixer: RTL

Sequential per-frame mixer between the voice bank and the audio codec interface. Once per DAC frame, on the rising edge of AUD_DACLRCK, it snapshots all voice outputs and per-voice gains. It multiply-accumulates them one voice per clock, applies a master volume, and saturates to 16 bits. The result drives LDATA/RDATA of the audio interface and replaces the plain truncating sum-and-shift, with clip detection for the software side.

---
 rtl/voice_mixer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/voice_mixer.sv
// Per-frame voice mixer: snapshots all voices on a DACLRCK rise, multiply-accumulates
// one voice per clock, applies master volume and saturates to SAMPLE_W with clip tracking.

module voice_mixer_lane #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cap,
    input  logic [SAMPLE_W-1:0] voice,
    input  logic [GAIN_W-1:0]   gain,
    output logic [SAMPLE_W-1:0] voice_q,
    output logic [GAIN_W-1:0]   gain_q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            voice_q <= '0;
            gain_q  <= '0;
        end else if (cap) begin
            voice_q <= voice;
            gain_q  <= gain;
        end
    end
endmodule

module voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
) (
    input  logic                           CLOCK_50,
    input  logic                           Reset,
    input  logic                           AUD_DACLRCK,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
    input  logic [NUM_VOICES*GAIN_W-1:0]   gain_in,
    input  logic [GAIN_W-1:0]              master_vol,
    input  logic                           clip_clr,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           clip,
    output logic [15:0]                    clip_count
);
    localparam int CNT_W  = $clog2(NUM_VOICES);
    localparam int IDX_W  = (NUM_VOICES > 1) ? CNT_W : 1;
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam int P_W    = ACC_W + GAIN_W + 1;
    localparam int SHIFT  = 2 * GAIN_W - 1;

    typedef enum logic [2:0] {IDLE, CAPTURE, MAC, SCALE, DONE} state_t;

    state_t state, state_nx;
    logic s1, s2, s3;
    logic frame_ev;
    logic [IDX_W-1:0] idx;
    logic [GAIN_W-1:0] master_q;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0] voice_q;
    logic [NUM_VOICES-1:0][GAIN_W-1:0]   gain_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [P_W-1:0]    p, y;
    logic sat;
    logic [SAMPLE_W-1:0] y_sat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_lane
            voice_mixer_lane #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) u_lane (
                .clk    (CLOCK_50),
                .rst    (Reset),
                .cap    (state == CAPTURE),
                .voice  (voice_in[gi*SAMPLE_W +: SAMPLE_W]),
                .gain   (gain_in[gi*GAIN_W +: GAIN_W]),
                .voice_q(voice_q[gi]),
                .gain_q (gain_q[gi])
            );
        end
    endgenerate

    assign frame_ev = s2 && !s3 && (state == IDLE);
    assign busy     = (state != IDLE);
    assign prod     = $signed(voice_q[idx]) * $signed({1'b0, gain_q[idx]});
    assign y        = p >>> SHIFT;
    // y fits SAMPLE_W only when every bit above the sign position matches it
    assign sat      = !((&y[P_W-1:SAMPLE_W-1]) || !(|y[P_W-1:SAMPLE_W-1]));
    assign y_sat    = y[P_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};

    always_ff @(posedge CLOCK_50) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (frame_ev) state_nx = CAPTURE;
            CAPTURE: state_nx = MAC;
            MAC:     if (idx == IDX_W'(NUM_VOICES - 1)) state_nx = SCALE;
            SCALE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            s3           <= 1'b1;
            idx          <= '0;
            acc          <= '0;
            p            <= '0;
            master_q     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
            clip_count   <= '0;
        end else begin
            s1           <= AUD_DACLRCK;
            s2           <= s1;
            s3           <= s2;
            sample_valid <= 1'b0;
            if (clip_clr) begin
                clip       <= 1'b0;
                clip_count <= '0;
            end
            case (state)
                CAPTURE: begin
                    acc      <= '0;
                    idx      <= '0;
                    master_q <= master_vol;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + IDX_W'(1);
                end
                SCALE: p <= P_W'(acc) * P_W'($signed({1'b0, master_q}));
                DONE: begin
                    sample_out   <= sat ? y_sat : y[SAMPLE_W-1:0];
                    sample_valid <= 1'b1;
                    // a clip event in the same cycle as clip_clr takes precedence
                    if (sat) begin
                        clip <= 1'b1;
                        if (clip_clr)                  clip_count <= 16'd1;
                        else if (clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
